// File: rtl/seg7_scan_decoder.sv
// Reads back a multiplexed 7-segment scan bus: debounces each scan slot and
// decodes the lit glyph of the selected digit into a per-position hex value.
//
// state  | meaning
// SETTLE | counting identical samples until the pattern is stable long enough
// HOLD   | stable pattern already committed; wait for the bus to change
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int DIGITS        = 8
) (
    input  logic                  clk100mhz,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     anodes,
    input  logic [7:0]            cathodes,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     dots,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_done,
    output logic                  glyph_error,
    output logic                  anode_error
);

    localparam int SW = DIGITS + 8;
    localparam logic [7:0] CNT_TC = 8'(STABLE_CYCLES - 2);

    typedef enum logic {SETTLE, HOLD} state_t;

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [SW-1:0]     samp, samp_prev;
    logic [DIGITS-1:0] seen, seen_set, low;
    logic [7:0]        s_cath;
    logic [6:0]        seg;
    logic              commit, changed, one_low, multi_low;
    logic              glyph_hit;
    logic [3:0]        glyph_val;

    assign low     = ~samp[SW-1:8];
    assign s_cath  = samp[7:0];
    assign seg     = ~s_cath[6:0];
    assign changed = (samp != samp_prev);

    assign one_low   = (low != '0) && ((low & (low - DIGITS'(1))) == '0);
    assign multi_low = (low != '0) && !one_low;
    assign seen_set  = seen | low;

    always_comb begin
        glyph_hit = 1'b1;
        glyph_val = 4'h0;
        case (seg)
            7'h3F: glyph_val = 4'h0;
            7'h06: glyph_val = 4'h1;
            7'h5B: glyph_val = 4'h2;
            7'h4F: glyph_val = 4'h3;
            7'h66: glyph_val = 4'h4;
            7'h6D: glyph_val = 4'h5;
            7'h7D: glyph_val = 4'h6;
            7'h07: glyph_val = 4'h7;
            7'h7F: glyph_val = 4'h8;
            7'h6F: glyph_val = 4'h9;
            7'h77: glyph_val = 4'hA;
            7'h7C: glyph_val = 4'hB;
            7'h39: glyph_val = 4'hC;
            7'h5E: glyph_val = 4'hD;
            7'h79: glyph_val = 4'hE;
            7'h71: glyph_val = 4'hF;
            default: glyph_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            SETTLE: begin
                if (changed) begin
                    cnt_nxt = 8'd0;
                end else begin
                    if (cnt == CNT_TC) begin
                        commit    = 1'b1;
                        state_nxt = HOLD;
                    end
                    if (cnt != 8'hFF) cnt_nxt = cnt + 8'd1;
                end
            end
            HOLD: begin
                if (changed) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = SETTLE;
                end
            end
            default: state_nxt = SETTLE;
        endcase
    end

    always_ff @(posedge clk100mhz or negedge reset) begin
        if (!reset) begin
            state <= SETTLE;
            cnt   <= 8'd0;
        end else if (clear) begin
            state <= SETTLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sample regs reset to an idle (all-off) bus so nothing bogus commits.
    always_ff @(posedge clk100mhz or negedge reset) begin
        if (!reset) begin
            samp        <= '1;
            samp_prev   <= '1;
            digits      <= '0;
            dots        <= '0;
            digit_valid <= '0;
            seen        <= '0;
            frame_done  <= 1'b0;
            glyph_error <= 1'b0;
            anode_error <= 1'b0;
        end else begin
            samp        <= {anodes, cathodes};
            samp_prev   <= samp;
            frame_done  <= 1'b0;
            glyph_error <= 1'b0;
            anode_error <= 1'b0;
            if (clear) begin
                digits      <= '0;
                dots        <= '0;
                digit_valid <= '0;
                seen        <= '0;
            end else if (commit) begin
                if (multi_low) begin
                    anode_error <= 1'b1;
                end else if (one_low) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (low[i]) begin
                            dots[i] <= ~s_cath[7];
                            if (glyph_hit) begin
                                digits[4*i +: 4] <= glyph_val;
                                digit_valid[i]   <= 1'b1;
                            end else if (seg == 7'h00) begin
                                digits[4*i +: 4] <= 4'h0;
                                digit_valid[i]   <= 1'b0;
                            end else begin
                                digit_valid[i]   <= 1'b0;
                                glyph_error      <= 1'b1;
                            end
                        end
                    end
                    if (&seen_set) begin
                        seen       <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        seen <= seen_set;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: table of scan slots with expected
// captured state, plus hand sequences for latency, clear and reset corners.
module tb_seg7_scan_decoder;

    logic        clk100mhz = 1'b0;
    logic        reset     = 1'b0;
    logic [7:0]  anodes    = 8'hFF;
    logic [7:0]  cathodes  = 8'hFF;
    logic        clear     = 1'b0;
    logic [31:0] digits;
    logic [7:0]  dots;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        glyph_error;
    logic        anode_error;

    int errors = 0;
    int checks = 0;

    seg7_scan_decoder #(.STABLE_CYCLES(4), .DIGITS(8)) dut (
        .clk100mhz   (clk100mhz),
        .reset       (reset),
        .anodes      (anodes),
        .cathodes    (cathodes),
        .clear       (clear),
        .digits      (digits),
        .dots        (dots),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .glyph_error (glyph_error),
        .anode_error (anode_error)
    );

    always #5 clk100mhz = ~clk100mhz;

    typedef struct {
        logic [7:0]  an;
        logic [7:0]  ca;
        logic [31:0] dg;
        logic [7:0]  dt;
        logic [7:0]  dv;
        logic        fd;
        logic        ge;
        logic        ae;
    } vec_t;

    vec_t tbl[33];

    function automatic vec_t mk(input logic [7:0] an, input logic [7:0] ca,
                                input logic [31:0] dg, input logic [7:0] dt,
                                input logic [7:0] dv, input logic fd,
                                input logic ge, input logic ae);
        vec_t v;
        v.an = an; v.ca = ca; v.dg = dg; v.dt = dt;
        v.dv = dv; v.fd = fd; v.ge = ge; v.ae = ae;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Pins change just after a falling edge; commit lands on the 5th rising edge.
    task automatic apply_row(input int k);
        anodes   = tbl[k].an;
        cathodes = tbl[k].ca;
        repeat (5) @(negedge clk100mhz);
        chk($sformatf("row%0d digits", k), digits, tbl[k].dg);
        chk($sformatf("row%0d dots", k), {24'h0, dots}, {24'h0, tbl[k].dt});
        chk($sformatf("row%0d valid", k), {24'h0, digit_valid}, {24'h0, tbl[k].dv});
        chk($sformatf("row%0d pulses", k), {29'h0, frame_done, glyph_error, anode_error},
            {29'h0, tbl[k].fd, tbl[k].ge, tbl[k].ae});
        @(negedge clk100mhz);
        chk($sformatf("row%0d pulse_end", k), {29'h0, frame_done, glyph_error, anode_error}, 32'h0);
        repeat (4) @(negedge clk100mhz);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        anodes   = 8'hFF;
        cathodes = 8'hFF;
        repeat (2) @(negedge clk100mhz);
        reset = 1'b1;
    endtask

    initial begin
        int bad;

        // first full scan: 0..7, dp on digit 7
        tbl[0]  = mk(8'hFE, 8'hC0, 32'h0000_0000, 8'h00, 8'h01, 0, 0, 0);
        tbl[1]  = mk(8'hFD, 8'hF9, 32'h0000_0010, 8'h00, 8'h03, 0, 0, 0);
        tbl[2]  = mk(8'hFB, 8'hA4, 32'h0000_0210, 8'h00, 8'h07, 0, 0, 0);
        tbl[3]  = mk(8'hF7, 8'hB0, 32'h0000_3210, 8'h00, 8'h0F, 0, 0, 0);
        tbl[4]  = mk(8'hEF, 8'h99, 32'h0004_3210, 8'h00, 8'h1F, 0, 0, 0);
        tbl[5]  = mk(8'hDF, 8'h92, 32'h0054_3210, 8'h00, 8'h3F, 0, 0, 0);
        tbl[6]  = mk(8'hBF, 8'h82, 32'h0654_3210, 8'h00, 8'h7F, 0, 0, 0);
        tbl[7]  = mk(8'h7F, 8'h78, 32'h7654_3210, 8'h80, 8'hFF, 1, 0, 0);
        // second full scan
        tbl[8]  = mk(8'hFE, 8'hC0, 32'h7654_3210, 8'h80, 8'hFF, 0, 0, 0);
        tbl[9]  = mk(8'hFD, 8'hF9, 32'h7654_3210, 8'h80, 8'hFF, 0, 0, 0);
        tbl[10] = mk(8'hFB, 8'hA4, 32'h7654_3210, 8'h80, 8'hFF, 0, 0, 0);
        tbl[11] = mk(8'hF7, 8'hB0, 32'h7654_3210, 8'h80, 8'hFF, 0, 0, 0);
        tbl[12] = mk(8'hEF, 8'h99, 32'h7654_3210, 8'h80, 8'hFF, 0, 0, 0);
        tbl[13] = mk(8'hDF, 8'h92, 32'h7654_3210, 8'h80, 8'hFF, 0, 0, 0);
        tbl[14] = mk(8'hBF, 8'h82, 32'h7654_3210, 8'h80, 8'hFF, 0, 0, 0);
        tbl[15] = mk(8'h7F, 8'h78, 32'h7654_3210, 8'h80, 8'hFF, 1, 0, 0);
        // two anodes, blanked digit, all-on glyph 8 with dp, garbage, blank slot
        tbl[16] = mk(8'hFC, 8'hB0, 32'h7654_3210, 8'h80, 8'hFF, 0, 0, 1);
        tbl[17] = mk(8'hFB, 8'hFF, 32'h7654_3010, 8'h80, 8'hFB, 0, 0, 0);
        tbl[18] = mk(8'hFB, 8'h00, 32'h7654_3810, 8'h84, 8'hFF, 0, 0, 0);
        tbl[19] = mk(8'hFB, 8'hB6, 32'h7654_3810, 8'h80, 8'hFB, 0, 1, 0);
        tbl[20] = mk(8'hFF, 8'hFF, 32'h7654_3810, 8'h80, 8'hFB, 0, 0, 0);
        // half frame before a mid-frame reset
        tbl[21] = mk(8'hFE, 8'hC0, 32'h0000_0000, 8'h00, 8'h01, 0, 0, 0);
        tbl[22] = mk(8'hFD, 8'hF9, 32'h0000_0010, 8'h00, 8'h03, 0, 0, 0);
        tbl[23] = mk(8'hFB, 8'hA4, 32'h0000_0210, 8'h00, 8'h07, 0, 0, 0);
        tbl[24] = mk(8'hF7, 8'hB0, 32'h0000_3210, 8'h00, 8'h0F, 0, 0, 0);
        // after reset: upper four alone must not complete a frame
        tbl[25] = mk(8'hEF, 8'h99, 32'h0004_0000, 8'h00, 8'h10, 0, 0, 0);
        tbl[26] = mk(8'hDF, 8'h92, 32'h0054_0000, 8'h00, 8'h30, 0, 0, 0);
        tbl[27] = mk(8'hBF, 8'h82, 32'h0654_0000, 8'h00, 8'h70, 0, 0, 0);
        tbl[28] = mk(8'h7F, 8'h78, 32'h7654_0000, 8'h80, 8'hF0, 0, 0, 0);
        tbl[29] = mk(8'hFE, 8'hC0, 32'h7654_0000, 8'h80, 8'hF1, 0, 0, 0);
        tbl[30] = mk(8'hFD, 8'hF9, 32'h7654_0010, 8'h80, 8'hF3, 0, 0, 0);
        tbl[31] = mk(8'hFB, 8'hA4, 32'h7654_0210, 8'h80, 8'hF7, 0, 0, 0);
        tbl[32] = mk(8'hF7, 8'hB0, 32'h7654_3210, 8'h80, 8'hFF, 1, 0, 0);

        // reset state
        repeat (2) @(negedge clk100mhz);
        chk("reset digits", digits, 32'h0);
        chk("reset flags", {dots, digit_valid, 5'h0, frame_done, glyph_error, anode_error}, 32'h0);
        reset = 1'b1;

        // static glyph 3 on digit 0: latency and single commit
        anodes   = 8'hFE;
        cathodes = 8'hB0;
        repeat (4) @(negedge clk100mhz);
        chk("latency edge4 valid", {24'h0, digit_valid}, 32'h0);
        @(negedge clk100mhz);
        chk("latency edge5 valid", {24'h0, digit_valid}, 32'h01);
        chk("latency edge5 digits", digits, 32'h3);
        chk("latency edge5 dots", {24'h0, dots}, 32'h0);
        chk("latency edge5 pulses", {29'h0, frame_done, glyph_error, anode_error}, 32'h0);
        bad = 0;
        repeat (100) begin
            @(negedge clk100mhz);
            if (frame_done || glyph_error || anode_error || digit_valid != 8'h01 || digits != 32'h3)
                bad++;
        end
        chk("static hold changes", bad, 0);

        // pattern toggling every 3 cycles never commits
        do_reset();
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            anodes   = (t % 2 == 0) ? 8'hFE : 8'hFD;
            cathodes = (t % 2 == 0) ? 8'hB0 : 8'hF9;
            repeat (3) begin
                @(negedge clk100mhz);
                if (digits != 0 || dots != 0 || digit_valid != 0 ||
                    frame_done || glyph_error || anode_error)
                    bad++;
            end
        end
        chk("toggle no commit", bad, 0);

        do_reset();
        for (int k = 0; k <= 20; k++) apply_row(k);

        // clear lands on the commit edge of a digit-0 glyph
        anodes   = 8'hFE;
        cathodes = 8'hB0;
        repeat (4) @(negedge clk100mhz);
        clear = 1'b1;
        @(negedge clk100mhz);
        clear    = 1'b0;
        anodes   = 8'hFF;
        cathodes = 8'hFF;
        chk("clear digits", digits, 32'h0);
        chk("clear flags", {8'h0, dots, digit_valid, 5'h0, frame_done, glyph_error, anode_error}, 32'h0);
        bad = 0;
        repeat (10) begin
            @(negedge clk100mhz);
            if (digits != 0 || dots != 0 || digit_valid != 0 ||
                frame_done || glyph_error || anode_error)
                bad++;
        end
        chk("clear aftermath", bad, 0);

        // mid-frame reset after four digits
        for (int k = 21; k <= 24; k++) apply_row(k);
        reset = 1'b0;
        #1;
        chk("async reset digits", digits, 32'h0);
        chk("async reset flags", {16'h0, dots, digit_valid}, 32'h0);
        @(negedge clk100mhz);
        @(negedge clk100mhz);
        reset = 1'b1;
        for (int k = 25; k <= 32; k++) apply_row(k);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
